// File: rtl/gf_arith_pkg.sv
// rtl/gf_arith_pkg.sv - op codes, FSM encoding and latency constants for gf_arith_unit
package gf_arith_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDSUB = 3'd1,
      ST_MUL    = 3'd2,
      ST_DIV    = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   localparam int LAT_ADDSUB = 2;

   function automatic int lat_mul(input int width);
      return width + 2;
   endfunction

   function automatic int lat_div_max(input int width);
      return 2 * width + 2;
   endfunction

endpackage

// File: rtl/gf_arith_unit_if.sv
// rtl/gf_arith_unit_if.sv - request/result bundle of gf_arith_unit
interface gf_arith_unit_if #(
   parameter int WIDTH = 33
);
   logic             i_valid;
   logic             o_ready;
   logic [1:0]       i_op;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic [WIDTH-1:0] i_prime;
   logic             o_valid;
   logic [WIDTH-1:0] o_result;
   logic             o_err;

   modport master (
      output i_valid, i_op, i_a, i_b, i_prime,
      input  o_ready, o_valid, o_result, o_err
   );

   modport slave (
      input  i_valid, i_op, i_a, i_b, i_prime,
      output o_ready, o_valid, o_result, o_err
   );
endinterface

// File: rtl/gf_mod_addsub.sv
// rtl/gf_mod_addsub.sv - combinational (x +/- y) mod p for x, y < p
module gf_mod_addsub #(
   parameter int WIDTH = 33
) (
   input  logic             i_sub,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic [WIDTH-1:0] i_p,
   output logic [WIDTH-1:0] o_z
);
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_sum_red;
   logic [WIDTH:0] w_wrap;

   // One extra bit keeps x+y and x+p-y exact before the single conditional reduction
   assign w_sum     = {1'b0, i_x} + {1'b0, i_y};
   assign w_sum_red = w_sum - {1'b0, i_p};
   assign w_wrap    = {1'b0, i_x} + {1'b0, i_p} - {1'b0, i_y};

   always_comb begin
      o_z = '0;
      if (i_sub) begin
         o_z = (i_x >= i_y) ? (i_x - i_y) : w_wrap[WIDTH-1:0];
      end else begin
         o_z = (w_sum >= {1'b0, i_p}) ? w_sum_red[WIDTH-1:0] : w_sum[WIDTH-1:0];
      end
   end
endmodule

// File: rtl/gf_arith_unit.sv
// rtl/gf_arith_unit.sv - GF(p) add/sub/mul/div unit with single-issue valid/ready front end
// Define GFAU_DIV_EN to build the binary extended-Euclid divider; otherwise op DIV returns o_err.
module gf_arith_unit
   import gf_arith_pkg::*;
#(
   parameter int WIDTH = 33
) (
   input  logic           i_clk,
   input  logic           i_rst,
   gf_arith_unit_if.slave bus
);
   localparam int CNT_W = $clog2(2 * WIDTH + 2);
   localparam logic [CNT_W-1:0] CNT_MUL_END = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_DIV_END = CNT_W'(2 * WIDTH);

   state_e           r_state;
   state_e           w_state_nxt;
   state_e           w_start_state;
   op_e              r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;
   logic             w_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_addsub;
   logic [WIDTH-1:0] w_dbl;
   logic [WIDTH-1:0] w_mac;

   assign w_ready      = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_accept     = bus.i_valid && w_ready;
   assign bus.o_ready  = w_ready;
   assign bus.o_valid  = (r_state == ST_DONE);
   assign bus.o_result = r_result;
   assign bus.o_err    = r_err;

   gf_mod_addsub #(.WIDTH(WIDTH)) u_addsub (
      .i_sub(r_op == OP_SUB), .i_x(r_a), .i_y(r_b), .i_p(r_p), .o_z(w_addsub)
   );

   // Double-and-add step: r' = 2r mod p, then optionally + a
   gf_mod_addsub #(.WIDTH(WIDTH)) u_dbl (
      .i_sub(1'b0), .i_x(r_acc), .i_y(r_acc), .i_p(r_p), .o_z(w_dbl)
   );

   gf_mod_addsub #(.WIDTH(WIDTH)) u_mac (
      .i_sub(1'b0), .i_x(w_dbl), .i_y(r_a), .i_p(r_p), .o_z(w_mac)
   );

`ifdef GFAU_DIV_EN
   logic [WIDTH-1:0] r_u;
   logic [WIDTH-1:0] r_v;
   logic [WIDTH-1:0] r_x1;
   logic [WIDTH-1:0] r_x2;
   logic [WIDTH:0]   w_x1_p;
   logic [WIDTH:0]   w_x2_p;
   logic [WIDTH-1:0] w_x1_half;
   logic [WIDTH-1:0] w_x2_half;
   logic [WIDTH-1:0] w_xsub;
   logic             w_u_ge_v;
   logic             w_div_stop;

   assign w_u_ge_v   = (r_u >= r_v);
   assign w_x1_p     = {1'b0, r_x1} + {1'b0, r_p};
   assign w_x2_p     = {1'b0, r_x2} + {1'b0, r_p};
   assign w_x1_half  = r_x1[0] ? w_x1_p[WIDTH:1] : {1'b0, r_x1[WIDTH-1:1]};
   assign w_x2_half  = r_x2[0] ? w_x2_p[WIDTH:1] : {1'b0, r_x2[WIDTH-1:1]};
   assign w_div_stop = (r_u == WIDTH'(1)) || (r_v == WIDTH'(1));

   // Shared subtractor: x1-x2 when u>=v, else x2-x1
   gf_mod_addsub #(.WIDTH(WIDTH)) u_xsub (
      .i_sub(1'b1),
      .i_x(w_u_ge_v ? r_x1 : r_x2),
      .i_y(w_u_ge_v ? r_x2 : r_x1),
      .i_p(r_p),
      .o_z(w_xsub)
   );
`endif

   always_comb begin
      w_start_state = ST_ADDSUB;
      case (op_e'(bus.i_op))
         OP_MUL: w_start_state = ST_MUL;
`ifdef GFAU_DIV_EN
         OP_DIV: if (bus.i_b != '0) w_start_state = ST_DIV;
`endif
         default: w_start_state = ST_ADDSUB;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_state_nxt = w_start_state;
         ST_ADDSUB: w_state_nxt = ST_DONE;
         ST_MUL:    if (r_cnt == CNT_MUL_END) w_state_nxt = ST_DONE;
`ifdef GFAU_DIV_EN
         ST_DIV:    if (w_div_stop || (r_cnt == CNT_DIV_END)) w_state_nxt = ST_DONE;
`endif
         ST_DONE:   w_state_nxt = w_accept ? w_start_state : ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_op     <= OP_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_p      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
`ifdef GFAU_DIV_EN
         r_u      <= '0;
         r_v      <= '0;
         r_x1     <= '0;
         r_x2     <= '0;
`endif
      end else begin
         if (w_accept) begin
            r_op  <= op_e'(bus.i_op);
            r_a   <= bus.i_a;
            r_b   <= bus.i_b;
            r_p   <= bus.i_prime;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef GFAU_DIV_EN
            r_u   <= bus.i_b;
            r_v   <= bus.i_prime;
            r_x1  <= bus.i_a;
            r_x2  <= '0;
`endif
         end
         case (r_state)
            // DIV only lands here when it must report an error (b==0 or no divider)
            ST_ADDSUB: begin
               r_result <= (r_op == OP_DIV) ? '0 : w_addsub;
               r_err    <= (r_op == OP_DIV);
            end
            ST_MUL: begin
               if (r_cnt == CNT_MUL_END) begin
                  r_result <= r_acc;
                  r_err    <= 1'b0;
               end else begin
                  r_acc <= r_b[WIDTH-1] ? w_mac : w_dbl;
                  r_b   <= {r_b[WIDTH-2:0], 1'b0};
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
`ifdef GFAU_DIV_EN
            ST_DIV: begin
               if (w_div_stop) begin
                  r_result <= (r_u == WIDTH'(1)) ? r_x1 : r_x2;
                  r_err    <= 1'b0;
               end else if (r_cnt == CNT_DIV_END) begin
                  r_result <= '0;
                  r_err    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (!r_u[0]) begin
                     r_u  <= r_u >> 1;
                     r_x1 <= w_x1_half;
                  end else if (!r_v[0]) begin
                     r_v  <= r_v >> 1;
                     r_x2 <= w_x2_half;
                  end else if (w_u_ge_v) begin
                     r_u  <= r_u - r_v;
                     r_x1 <= w_xsub;
                  end else begin
                     r_v  <= r_v - r_u;
                     r_x2 <= w_xsub;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_gf_arith_unit.sv
// tb/tb_gf_arith_unit.sv - scoreboard bench for gf_arith_unit at WIDTH=8
module tb_gf_arith_unit;
   import gf_arith_pkg::*;

   localparam int W = 8;

   typedef struct {
      int unsigned res;
      bit          err;
      int          lat;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gf_arith_unit_if #(.WIDTH(W)) bus ();
   gf_arith_unit #(.WIDTH(W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic exp_t model(input op_e op, input int unsigned a, input int unsigned b,
                                  input int unsigned p, input string tag);
      exp_t e;
      longint unsigned inv, base, ex;
      e.tag = tag;
      e.err = 1'b0;
      e.res = 0;
      e.lat = LAT_ADDSUB;
      case (op)
         OP_ADD: e.res = (a + b) % p;
         OP_SUB: e.res = (a + p - b) % p;
         OP_MUL: begin
            e.res = (a * b) % p;
            e.lat = lat_mul(W);
         end
         default: begin
`ifdef GFAU_DIV_EN
            if (b != 0) begin
               inv  = 1;
               base = longint'(b);
               ex   = longint'(p - 2);
               while (ex != 0) begin
                  if (ex[0]) inv = (inv * base) % p;
                  base = (base * base) % p;
                  ex   = ex >> 1;
               end
               e.res = int'((longint'(a) * inv) % p);
               e.lat = 0;
            end else begin
               e.err = 1'b1;
            end
`else
            e.err = 1'b1;
`endif
         end
      endcase
      return e;
   endfunction

   task automatic compare_pulse(input string tag);
      exp_t e;
      chk({tag, "_sb_has_entry"}, (sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.tag, "_result"}, bus.o_result, e.res);
         chk({e.tag, "_err"}, bus.o_err, e.err);
      end
   endtask

   task automatic issue(input op_e op, input int unsigned a, input int unsigned b,
                        input int unsigned p, input string tag);
      @(negedge clk);
      chk({tag, "_ready_idle"}, bus.o_ready, 1);
      sb.push_back(model(op, a, b, p, tag));
      bus.i_valid = 1'b1;
      bus.i_op    = op;
      bus.i_a     = W'(a);
      bus.i_b     = W'(b);
      bus.i_prime = W'(p);
      @(posedge clk);
      #1;
      // Garbage after accept must not disturb the captured operands
      bus.i_valid = 1'b0;
      bus.i_a     = W'(~a);
      bus.i_b     = W'(~b);
      bus.i_prime = W'(~p);
      bus.i_op    = 2'(~op);
   endtask

   task automatic wait_done(input string tag, input int k0);
      int   k = k0;
      bit   got = 1'b0;
      bit   ready_low = 1'b1;
      int   lat_exp;
      lat_exp = (sb.size() > 0) ? sb[0].lat : 0;
      while (!got && k < 100) begin
         @(negedge clk);
         k++;
         if (bus.o_valid) got = 1'b1;
         else if (bus.o_ready !== 1'b0) ready_low = 1'b0;
      end
      chk({tag, "_valid_seen"}, got, 1);
      chk({tag, "_ready_low_busy"}, ready_low, 1);
      chk({tag, "_ready_on_valid"}, bus.o_ready, 1);
      if (lat_exp > 0) chk({tag, "_latency"}, k, lat_exp);
      else             chk({tag, "_latency_bound"}, (k <= lat_div_max(W)), 1);
      compare_pulse(tag);
   endtask

   task automatic op_run(input op_e op, input int unsigned a, input int unsigned b,
                         input int unsigned p, input string tag);
      issue(op, a, b, p, tag);
      wait_done(tag, 0);
   endtask

   task automatic quiet(input string tag, input int n);
      int pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.o_valid) pulses++;
      end
      chk({tag, "_no_stray_valid"}, pulses, 0);
   endtask

   initial begin
      exp_t        tmp;
      int unsigned plist[3];
      int          acc;
      int          pulses;
      int          k;

      plist = '{251, 3, 197};
      rst         = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_op    = '0;
      bus.i_a     = '0;
      bus.i_b     = '0;
      bus.i_prime = '0;
      repeat (3) @(negedge clk);
      chk("reset_ready", bus.o_ready, 1);
      chk("reset_valid", bus.o_valid, 0);
      chk("reset_result", bus.o_result, 0);
      chk("reset_err", bus.o_err, 0);
      rst = 1'b0;

      op_run(OP_ADD, 200, 100, 251, "add_200_100");
      op_run(OP_ADD, 250, 1, 251, "add_wrap_to_0");
      op_run(OP_SUB, 5, 10, 251, "sub_5_10");
      op_run(OP_SUB, 10, 10, 251, "sub_10_10");
      op_run(OP_MUL, 17, 15, 251, "mul_17_15");
      op_run(OP_MUL, 0, 123, 251, "mul_0_123");
      op_run(OP_DIV, 1, 2, 251, "div_1_2");
      op_run(OP_DIV, 6, 4, 251, "div_6_4");
      op_run(OP_DIV, 7, 0, 251, "div_by_zero");
      op_run(OP_MUL, 250, 250, 251, "mul_250_250");

      // Reset during MUL: the aborted request must never produce a pulse
      issue(OP_MUL, 17, 15, 251, "mul_rst");
      tmp = sb.pop_back();
      k = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.o_valid) k++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mul_rst_no_early_valid", k, 0);
      chk("mul_rst_ready", bus.o_ready, 1);
      chk("mul_rst_result", bus.o_result, 0);
      chk("mul_rst_err", bus.o_err, 0);
      quiet("mul_rst", 20);

      // Request while a MUL is busy is dropped, not queued
      issue(OP_MUL, 3, 5, 251, "mul_busy");
      repeat (2) @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_op    = OP_ADD;
      bus.i_a     = 8'd1;
      bus.i_b     = 8'd1;
      bus.i_prime = 8'd251;
      @(negedge clk);
      bus.i_valid = 1'b0;
      wait_done("mul_busy", 3);
      quiet("mul_busy", 15);

      // i_valid held high across three ADDs
      acc = 0;
      pulses = 0;
      k = 0;
      while (k < 30 && (acc < 3 || pulses < 3)) begin
         @(negedge clk);
         k++;
         if (bus.o_valid) begin
            pulses++;
            compare_pulse("b2b");
         end
         if (bus.o_ready && acc < 3) begin
            sb.push_back(model(OP_ADD, 40 * acc + 7, 100 + acc, 251, "b2b_add"));
            bus.i_valid = 1'b1;
            bus.i_op    = OP_ADD;
            bus.i_a     = W'(40 * acc + 7);
            bus.i_b     = W'(100 + acc);
            bus.i_prime = 8'd251;
            acc++;
         end else if (bus.o_ready) begin
            bus.i_valid = 1'b0;
         end
      end
      bus.i_valid = 1'b0;
      chk("b2b_pulses", pulses, 3);
      chk("b2b_cycles", k, 7);
      quiet("b2b", 10);

      for (int i = 0; i < 6; i++) begin
         int unsigned p, a, b;
         op_e op;
         p  = plist[i % 3];
         a  = $urandom % p;
         b  = $urandom % p;
         op = op_e'($urandom_range(0, 2));
         op_run(op, a, b, p, "rand_op");
      end

      chk("sb_empty_at_end", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
